ysyx_23060203_lsu: RTL and testbench
====================================

Name: ysyx_23060203_lsu

Overview:
- Load/store unit directly downstream of the execute stage. Consumes the execute stage's memory request: read/write enable, funct3, ALU-computed address and store data.
- Runs a multi-cycle transaction on a word-wide memory bus, with per-byte write strobes.
- Returns sign/zero-extended load data, or an error flag, through a valid/ready result port to writeback.

Parameters:
- TIMEOUT, 255: max cycles spent in ADDR+WAIT before the op is aborted with error; legal range 1..65535.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rstn  in  1  reset; one clock; reset is synchronous and active-low
- in_valid  in  1  execute stage presents a request
- in_ready  out  1  LSU can accept a request
- in_ren  in  1  load request
- in_wen  in  1  store request
- in_func  in  3  RISC-V funct3 of the load/store
- in_addr  in  32  byte address
- in_wdata  in  32  store data, unaligned, low bits significant
- out_valid  out  1  result available
- out_ready  in  1  writeback consumes result
- out_rdata  out  32  extended load data; 0 for stores, no-ops and errors
- out_err  out  1  misaligned, illegal func, or bus timeout
- mem_req_valid  out  1  bus request valid
- mem_req_ready  in  1  bus accepts request
- mem_req_wen  out  1  1 = write, 0 = read
- mem_req_addr  out  32  word address {in_addr[31:2],2'b00}
- mem_req_wdata  out  32  lane-replicated store data
- mem_req_wstrb  out  4  byte strobes; 0 on reads
- mem_resp_valid  in  1  bus response (read data or write ack), single-cycle pulse
- mem_resp_rdata  in  32  read word

Behaviour:
- States: IDLE, ADDR, WAIT, RESP. Reset (rstn=0 at an edge): state IDLE. Every output 0 except in_ready=1. Timeout counter 0. An in-flight bus request is dropped mid-op.
- in_ready=1 only in IDLE. Accept = in_valid & in_ready; request fields are latched on the accept edge.
- Accept decode:
  - in_ren=in_wen=0 -> RESP, out_rdata=0, err=0, no bus op.
  - in_ren=in_wen=1 -> RESP, err=1.
  - Load func legal: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Store func legal: 000 SB, 001 SH, 010 SW. Other func -> RESP, err=1.
  - Misaligned (halfword with addr[0]=1; word with addr[1:0]!=0) -> RESP, err=1, no bus op.
  - Otherwise -> ADDR.
- ADDR: mem_req_valid=1; all mem_req_* fields held stable until mem_req_ready=1 at an edge, then -> WAIT with mem_req_valid=0 next cycle.
- WAIT: on mem_resp_valid=1 -> RESP. For loads, the formatted data is registered into out_rdata:
  - k = addr[1:0]; byte = rdata[8k+7:8k]; half = rdata[8k+15:8k].
  - LB/LH sign-extend, LBU/LHU zero-extend, LW full word.
- Store encoding:
  - SB: wstrb = 0001<<k, wdata = {4{wdata[7:0]}}.
  - SH: wstrb = 0011<<k, wdata = {2{wdata[15:0]}}.
  - SW: wstrb = 1111, wdata = wdata.
- Timeout: counter clears on accept and increments each cycle in ADDR or WAIT. When it equals TIMEOUT without completion -> RESP, err=1, out_rdata=0, mem_req_valid drops.
- mem_resp_valid outside WAIT is ignored, including a late response after a timeout.
- RESP: out_valid=1, out_rdata/out_err stable until out_ready=1 at an edge, then -> IDLE.
  - out_valid deasserts the following cycle.
  - No new accept in the same cycle as the result handshake; in_ready rises the cycle after.
- Minimum latency with a zero-wait bus (mem_req_ready=1 in the first ADDR cycle, mem_resp_valid in the first WAIT cycle):
  - Accept at edge 0, request handshake edge 1, response edge 2.
  - out_valid high in the cycle after edge 2.
  - Decode-only ops (no-op or error): out_valid high in the cycle after the accept edge.
- Reset asserted in any state wins over all events at that edge.

Test Plan:
1. LB addr=0x80000003, mem word 0x80FF1234 -> mem_req_addr=0x80000000, wstrb=0000, out_rdata=0xFFFFFF80, err=0. Same with LBU -> 0x00000080.
2. SH addr=0x80000006, wdata=0xDEADBEEF -> wstrb=1100, mem_req_wdata=0xBEEFBEEF, out_rdata=0, err=0. mem_req_valid held 3 cycles while mem_req_ready=0, fields stable throughout.
3. LW addr=0x80000002 -> no mem_req_valid, out_valid the cycle after accept, err=1. func=011 load -> err=1. ren=wen=1 -> err=1.
4. TIMEOUT=4, LW with mem_req_ready stuck 0 -> err=1 after exactly 4 ADDR cycles. A mem_resp_valid pulse injected two cycles later is ignored, and the next LW completes with correct data.
5. out_ready held 0 for 5 cycles in RESP -> out_valid/out_rdata stable and in_ready=0 throughout. Back-to-back loads with out_ready=1 -> in_ready rises the cycle after each handshake.
6. rstn=0 for one edge while in WAIT -> IDLE, in_ready=1, mem_req_valid=0, out_valid=0. A stale mem_resp_valid after the reset produces no out_valid.

Source files
------------

// File: rtl/ysyx_23060203_lsu_if.sv
// Execute/writeback/memory-bus signal bundle of the load/store unit.
// slave is the LSU's view; master is the environment (execute, writeback and memory).
interface ysyx_23060203_lsu_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_ren;
  logic        in_wen;
  logic [2:0]  in_func;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rdata;
  logic        out_err;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_wen;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;

  modport slave (
    input  in_valid, in_ren, in_wen, in_func, in_addr, in_wdata,
    input  out_ready, mem_req_ready, mem_resp_valid, mem_resp_rdata,
    output in_ready, out_valid, out_rdata, out_err,
    output mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wstrb
  );

  modport master (
    output in_valid, in_ren, in_wen, in_func, in_addr, in_wdata,
    output out_ready, mem_req_ready, mem_resp_valid, mem_resp_rdata,
    input  in_ready, out_valid, out_rdata, out_err,
    input  mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wstrb
  );
endinterface

// File: rtl/ysyx_23060203_lsu.sv
// Load/store unit: decodes an execute-stage memory request, runs one word-bus
// transaction with byte strobes, and returns extended load data or an error flag.
module ysyx_23060203_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic                  clk,
  input logic                  rstn,
  ysyx_23060203_lsu_if.slave   io
);

  typedef enum logic [1:0] {IDLE, ADDR, WAIT, RESP} state_t;

  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

  state_t      state;
  logic [15:0] tmo_cnt;
  logic [2:0]  func_q;
  logic [1:0]  off_q;
  logic        load_q;

  logic        accept;
  logic        legal;
  logic        misaligned;
  logic [3:0]  wstrb_d;
  logic [31:0] wdata_d;
  logic [31:0] shifted;
  logic [31:0] load_data;
  logic [15:0] cnt_next;
  logic        expired;

  assign accept   = io.in_valid && io.in_ready;
  assign cnt_next = tmo_cnt + 16'd1;
  assign expired  = (cnt_next == TIMEOUT_W);

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
    legal      = 1'b0;
    misaligned = 1'b0;
    wstrb_d    = 4'b1111;
    wdata_d    = io.in_wdata;

    if (io.in_ren) begin
      legal = io.in_func inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    end else begin
      legal = io.in_func inside {3'b000, 3'b001, 3'b010};
    end

    case (io.in_func[1:0])
      2'b01:   misaligned = io.in_addr[0];
      2'b10:   misaligned = (io.in_addr[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase

    // Sub-word stores replicate the data across lanes; the strobe selects the lane.
    case (io.in_func[1:0])
      2'b00: begin
        wstrb_d = 4'b0001 << io.in_addr[1:0];
        wdata_d = {4{io.in_wdata[7:0]}};
      end
      2'b01: begin
        wstrb_d = 4'b0011 << io.in_addr[1:0];
        wdata_d = {2{io.in_wdata[15:0]}};
      end
      default: begin
        wstrb_d = 4'b1111;
        wdata_d = io.in_wdata;
      end
    endcase
  end

  always_comb begin
    shifted   = io.mem_resp_rdata >> {off_q, 3'b000};
    load_data = io.mem_resp_rdata;
    case (func_q)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_data = {24'd0, shifted[7:0]};
      3'b101:  load_data = {16'd0, shifted[15:0]};
      default: load_data = io.mem_resp_rdata;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state            <= IDLE;
      tmo_cnt          <= 16'd0;
      func_q           <= 3'd0;
      off_q            <= 2'd0;
      load_q           <= 1'b0;
      io.in_ready      <= 1'b1;
      io.out_valid     <= 1'b0;
      io.out_rdata     <= 32'd0;
      io.out_err       <= 1'b0;
      io.mem_req_valid <= 1'b0;
      io.mem_req_wen   <= 1'b0;
      io.mem_req_addr  <= 32'd0;
      io.mem_req_wdata <= 32'd0;
      io.mem_req_wstrb <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            func_q      <= io.in_func;
            off_q       <= io.in_addr[1:0];
            load_q      <= io.in_ren;
            tmo_cnt     <= 16'd0;
            io.in_ready <= 1'b0;
            if (!io.in_ren && !io.in_wen) begin
              state        <= RESP;
              io.out_valid <= 1'b1;
              io.out_rdata <= 32'd0;
              io.out_err   <= 1'b0;
            end else if ((io.in_ren && io.in_wen) || !legal || misaligned) begin
              state        <= RESP;
              io.out_valid <= 1'b1;
              io.out_rdata <= 32'd0;
              io.out_err   <= 1'b1;
            end else begin
              state            <= ADDR;
              io.mem_req_valid <= 1'b1;
              io.mem_req_wen   <= io.in_wen;
              io.mem_req_addr  <= {io.in_addr[31:2], 2'b00};
              io.mem_req_wdata <= io.in_wen ? wdata_d : 32'd0;
              io.mem_req_wstrb <= io.in_wen ? wstrb_d : 4'd0;
            end
          end
        end

        ADDR: begin
          tmo_cnt <= cnt_next;
          // An abort takes precedence over a request handshake on the same edge.
          if (expired) begin
            state            <= RESP;
            io.mem_req_valid <= 1'b0;
            io.out_valid     <= 1'b1;
            io.out_rdata     <= 32'd0;
            io.out_err       <= 1'b1;
          end else if (io.mem_req_ready) begin
            state            <= WAIT;
            io.mem_req_valid <= 1'b0;
          end
        end

        WAIT: begin
          tmo_cnt <= cnt_next;
          if (io.mem_resp_valid) begin
            state        <= RESP;
            io.out_valid <= 1'b1;
            io.out_rdata <= load_q ? load_data : 32'd0;
            io.out_err   <= 1'b0;
          end else if (expired) begin
            state        <= RESP;
            io.out_valid <= 1'b1;
            io.out_rdata <= 32'd0;
            io.out_err   <= 1'b1;
          end
        end

        RESP: begin
          if (io.out_ready) begin
            state        <= IDLE;
            io.out_valid <= 1'b0;
            io.out_rdata <= 32'd0;
            io.out_err   <= 1'b0;
            io.in_ready  <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060203_lsu.sv
// Directed bench for the LSU: results are predicted into a scoreboard queue at
// issue time and compared when the writeback handshake happens.
module tb_ysyx_23060203_lsu;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  ysyx_23060203_lsu_if u ();
  ysyx_23060203_lsu_if t ();

  ysyx_23060203_lsu #(.TIMEOUT(255)) dut    (.clk(clk), .rstn(rstn), .io(u));
  ysyx_23060203_lsu #(.TIMEOUT(4))   dut_to (.clk(clk), .rstn(rstn), .io(t));

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       tag;
  } res_t;

  res_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_res(string tag, logic [31:0] rd, logic err);
    res_t r;
    r.rdata = rd;
    r.err   = err;
    r.tag   = tag;
    exp_q.push_back(r);
  endtask

  // Scoreboard: compare on the cycle a result handshake completes.
  always @(negedge clk) begin
    if (rstn === 1'b1 && u.out_valid === 1'b1 && u.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        check({e.tag, "_rdata"}, u.out_rdata, e.rdata);
        check({e.tag, "_err"}, {31'd0, u.out_err}, {31'd0, e.err});
      end
    end
  end

  task automatic issue(logic ren, logic wen, logic [2:0] f, logic [31:0] a, logic [31:0] wd);
    int n = 0;
    while (u.in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("issue_in_ready", {31'd0, u.in_ready}, 32'd1);
    u.in_valid = 1'b1;
    u.in_ren   = ren;
    u.in_wen   = wen;
    u.in_func  = f;
    u.in_addr  = a;
    u.in_wdata = wd;
    tick();
    u.in_valid = 1'b0;
  endtask

  task automatic bus_txn(string tag, int stalls, logic [31:0] rword, logic [31:0] w_addr,
                         logic [3:0] w_strb, logic [31:0] w_wdata, logic w_wen);
    check({tag, "_req_valid"}, {31'd0, u.mem_req_valid}, 32'd1);
    check({tag, "_req_addr"}, u.mem_req_addr, w_addr);
    check({tag, "_req_wstrb"}, {28'd0, u.mem_req_wstrb}, {28'd0, w_strb});
    check({tag, "_req_wdata"}, u.mem_req_wdata, w_wdata);
    check({tag, "_req_wen"}, {31'd0, u.mem_req_wen}, {31'd0, w_wen});
    for (int i = 0; i < stalls; i++) begin
      u.mem_req_ready = 1'b0;
      tick();
      check({tag, "_stall_valid"}, {31'd0, u.mem_req_valid}, 32'd1);
      check({tag, "_stall_addr"}, u.mem_req_addr, w_addr);
      check({tag, "_stall_wstrb"}, {28'd0, u.mem_req_wstrb}, {28'd0, w_strb});
      check({tag, "_stall_wdata"}, u.mem_req_wdata, w_wdata);
    end
    u.mem_req_ready = 1'b1;
    tick();
    u.mem_req_ready = 1'b0;
    check({tag, "_req_drop"}, {31'd0, u.mem_req_valid}, 32'd0);
    check({tag, "_wait_no_out"}, {31'd0, u.out_valid}, 32'd0);
    u.mem_resp_valid = 1'b1;
    u.mem_resp_rdata = rword;
    tick();
    u.mem_resp_valid = 1'b0;
    check({tag, "_out_valid"}, {31'd0, u.out_valid}, 32'd1);
  endtask

  task automatic drain(string tag, int hold);
    logic [31:0] rd;
    logic        er;
    rd = u.out_rdata;
    er = u.out_err;
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold_valid"}, {31'd0, u.out_valid}, 32'd1);
      check({tag, "_hold_rdata"}, u.out_rdata, rd);
      check({tag, "_hold_err"}, {31'd0, u.out_err}, {31'd0, er});
      check({tag, "_hold_in_ready"}, {31'd0, u.in_ready}, 32'd0);
    end
    u.out_ready = 1'b1;
    tick();
    u.out_ready = 1'b0;
    check({tag, "_post_valid"}, {31'd0, u.out_valid}, 32'd0);
    check({tag, "_post_in_ready"}, {31'd0, u.in_ready}, 32'd1);
  endtask

  task automatic decode_only(string tag, logic ren, logic wen, logic [2:0] f,
                             logic [31:0] a, logic err);
    expect_res(tag, 32'd0, err);
    issue(ren, wen, f, a, 32'hFFFF_FFFF);
    check({tag, "_no_req"}, {31'd0, u.mem_req_valid}, 32'd0);
    check({tag, "_out_valid"}, {31'd0, u.out_valid}, 32'd1);
    drain(tag, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    {u.in_valid, u.in_ren, u.in_wen, u.out_ready, u.mem_req_ready, u.mem_resp_valid} = '0;
    u.in_func = '0; u.in_addr = '0; u.in_wdata = '0; u.mem_resp_rdata = '0;
    {t.in_valid, t.in_ren, t.in_wen, t.out_ready, t.mem_req_ready, t.mem_resp_valid} = '0;
    t.in_func = '0; t.in_addr = '0; t.in_wdata = '0; t.mem_resp_rdata = '0;

    rstn = 1'b0;
    tick();
    tick();
    check("rst_in_ready", {31'd0, u.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, u.out_valid}, 32'd0);
    check("rst_out_rdata", u.out_rdata, 32'd0);
    check("rst_out_err", {31'd0, u.out_err}, 32'd0);
    check("rst_req_valid", {31'd0, u.mem_req_valid}, 32'd0);
    check("rst_req_addr", u.mem_req_addr, 32'd0);
    check("rst_req_wstrb", {28'd0, u.mem_req_wstrb}, 32'd0);
    rstn = 1'b1;

    // Loads with sign and zero extension on a zero-wait bus.
    expect_res("lb", 32'hFFFF_FF80, 1'b0);
    issue(1'b1, 1'b0, 3'b000, 32'h8000_0003, 32'd0);
    bus_txn("lb", 0, 32'h80FF_1234, 32'h8000_0000, 4'b0000, 32'd0, 1'b0);
    drain("lb", 0);

    expect_res("lbu", 32'h0000_0080, 1'b0);
    issue(1'b1, 1'b0, 3'b100, 32'h8000_0003, 32'd0);
    bus_txn("lbu", 0, 32'h80FF_1234, 32'h8000_0000, 4'b0000, 32'd0, 1'b0);
    drain("lbu", 0);

    // Stores, including a stalled request.
    expect_res("sh", 32'd0, 1'b0);
    issue(1'b0, 1'b1, 3'b001, 32'h8000_0006, 32'hDEAD_BEEF);
    bus_txn("sh", 3, 32'h1234_5678, 32'h8000_0004, 4'b1100, 32'hBEEF_BEEF, 1'b1);
    drain("sh", 0);

    expect_res("sb", 32'd0, 1'b0);
    issue(1'b0, 1'b1, 3'b000, 32'h8000_0001, 32'h1234_56A5);
    bus_txn("sb", 0, 32'h0, 32'h8000_0000, 4'b0010, 32'hA5A5_A5A5, 1'b1);
    drain("sb", 0);

    expect_res("sw", 32'd0, 1'b0);
    issue(1'b0, 1'b1, 3'b010, 32'h8000_000C, 32'h0102_0304);
    bus_txn("sw", 1, 32'h0, 32'h8000_000C, 4'b1111, 32'h0102_0304, 1'b1);
    drain("sw", 0);

    // Decode-time results: no bus activity.
    decode_only("lw_misalign", 1'b1, 1'b0, 3'b010, 32'h8000_0002, 1'b1);
    decode_only("lh_misalign", 1'b1, 1'b0, 3'b001, 32'h8000_0001, 1'b1);
    decode_only("load_f011", 1'b1, 1'b0, 3'b011, 32'h8000_0000, 1'b1);
    decode_only("store_f100", 1'b0, 1'b1, 3'b100, 32'h8000_0000, 1'b1);
    decode_only("ren_wen", 1'b1, 1'b1, 3'b000, 32'h8000_0000, 1'b1);
    decode_only("noop", 1'b0, 1'b0, 3'b010, 32'h8000_0003, 1'b0);

    // Writeback backpressure, then back-to-back loads.
    expect_res("lw_hold", 32'hCAFE_F00D, 1'b0);
    issue(1'b1, 1'b0, 3'b010, 32'h8000_0008, 32'd0);
    bus_txn("lw_hold", 0, 32'hCAFE_F00D, 32'h8000_0008, 4'b0000, 32'd0, 1'b0);
    drain("lw_hold", 5);

    expect_res("lh_b2b", 32'hFFFF_80FF, 1'b0);
    issue(1'b1, 1'b0, 3'b001, 32'h8000_0002, 32'd0);
    bus_txn("lh_b2b", 0, 32'h80FF_1234, 32'h8000_0000, 4'b0000, 32'd0, 1'b0);
    drain("lh_b2b", 0);
    expect_res("lhu_b2b", 32'h0000_1234, 1'b0);
    issue(1'b1, 1'b0, 3'b101, 32'h8000_0000, 32'd0);
    bus_txn("lhu_b2b", 0, 32'h80FF_1234, 32'h8000_0000, 4'b0000, 32'd0, 1'b0);
    drain("lhu_b2b", 0);

    // Timeout on the TIMEOUT=4 instance with the bus never accepting.
    t.in_valid = 1'b1; t.in_ren = 1'b1; t.in_wen = 1'b0;
    t.in_func = 3'b010; t.in_addr = 32'h8000_0010;
    tick();
    t.in_valid = 1'b0;
    n = 0;
    while (t.mem_req_valid === 1'b1 && t.out_valid !== 1'b1 && n < 20) begin
      n++;
      tick();
    end
    check("to_addr_cycles", n, 32'd4);
    check("to_out_valid", {31'd0, t.out_valid}, 32'd1);
    check("to_err", {31'd0, t.out_err}, 32'd1);
    check("to_rdata", t.out_rdata, 32'd0);
    check("to_req_drop", {31'd0, t.mem_req_valid}, 32'd0);
    t.out_ready = 1'b1;
    tick();
    t.out_ready = 1'b0;
    check("to_in_ready", {31'd0, t.in_ready}, 32'd1);
    t.mem_resp_valid = 1'b1;
    t.mem_resp_rdata = 32'hDEAD_0000;
    tick();
    t.mem_resp_valid = 1'b0;
    tick();
    check("to_late_resp_ignored", {31'd0, t.out_valid}, 32'd0);
    check("to_late_in_ready", {31'd0, t.in_ready}, 32'd1);
    t.mem_req_ready = 1'b1;
    t.in_valid = 1'b1;
    tick();
    t.in_valid = 1'b0;
    tick();
    t.mem_req_ready = 1'b0;
    t.mem_resp_valid = 1'b1;
    t.mem_resp_rdata = 32'h1122_3344;
    tick();
    t.mem_resp_valid = 1'b0;
    check("to_next_valid", {31'd0, t.out_valid}, 32'd1);
    check("to_next_rdata", t.out_rdata, 32'h1122_3344);
    check("to_next_err", {31'd0, t.out_err}, 32'd0);
    t.out_ready = 1'b1;
    tick();
    t.out_ready = 1'b0;

    // Reset while waiting for a response, then a stale response.
    issue(1'b1, 1'b0, 3'b010, 32'h8000_0020, 32'd0);
    u.mem_req_ready = 1'b1;
    tick();
    u.mem_req_ready = 1'b0;
    check("rw_in_wait", {31'd0, u.mem_req_valid}, 32'd0);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check("rw_in_ready", {31'd0, u.in_ready}, 32'd1);
    check("rw_req_valid", {31'd0, u.mem_req_valid}, 32'd0);
    check("rw_out_valid", {31'd0, u.out_valid}, 32'd0);
    u.mem_resp_valid = 1'b1;
    u.mem_resp_rdata = 32'h5555_AAAA;
    tick();
    u.mem_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rw_stale_out_valid", {31'd0, u.out_valid}, 32'd0);
      tick();
    end

    check("sb_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
